// File: rtl/switch_port_out.sv
// Output-side queue of one switch port.
// Buffers fabric bytes in a small FIFO and exposes them to the port consumer
// only once a complete packet (last-flagged byte) is stored. The head byte is
// presented first-word-fall-through while ready is high.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no complete packet buffered; ready=0, data forced to 8'h00
// SEND  | at least one complete packet buffered; consumer may pop
module switch_port_out #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_full,
   output logic [7:0]       data,
   output logic             ready,
   input  logic             read,
   output logic [CNT_W-1:0] pkt_count,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   logic [8:0]       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] occupancy;

   logic             wr_en;
   logic             rd_en;
   logic [8:0]       head;
   logic             push_last;
   logic             pop_last;
   logic [CNT_W-1:0] pkt_count_nxt;

   // Fullness is judged before any same-cycle pop, so a write at full is always dropped.
   assign in_full   = (occupancy == CNT_W'(DEPTH));
   assign wr_en     = in_valid && !in_full;
   assign rd_en     = read && ready;
   assign head      = mem[rd_ptr];
   assign push_last = wr_en && in_last;
   assign pop_last  = rd_en && head[8];
   assign data      = ready ? head[7:0] : 8'h00;

   // Packet count after this cycle's write and pop; a simultaneous +1/-1 cancels.
   always_comb begin
      pkt_count_nxt = pkt_count;
      if (push_last && !pop_last)
         pkt_count_nxt = pkt_count + CNT_W'(1);
      else if (!push_last && pop_last)
         pkt_count_nxt = pkt_count - CNT_W'(1);
   end

   // Storage array: {last, byte} per entry; no reset needed, pointers gate visibility.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= {in_last, in_data};
   end

   // Pointers, occupancy, packet count and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         pkt_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   occupancy <= occupancy + CNT_W'(1);
            2'b01:   occupancy <= occupancy - CNT_W'(1);
            default: occupancy <= occupancy;
         endcase
         pkt_count <= pkt_count_nxt;
         if (in_valid && in_full)
            overflow <= 1'b1;
      end
   end

   // Store-and-forward FSM; ready is a registered copy of the SEND state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pkt_count != '0) begin
                  state <= SEND;
                  ready <= 1'b1;
               end
            end
            SEND: begin
               if (pop_last && (pkt_count_nxt == '0)) begin
                  state <= IDLE;
                  ready <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_switch_port_out.sv
// Directed bench for switch_port_out: store-and-forward gating, FWFT readout,
// back-to-back packets, full/overflow, simultaneous write/pop, reset flush.
module tb_switch_port_out;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_full;
   logic [7:0] data;
   logic       ready;
   logic       read;
   logic [4:0] pkt_count;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;

   switch_port_out #(.DEPTH(16), .CNT_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_full   (in_full),
      .data      (data),
      .ready     (ready),
      .read      (read),
      .pkt_count (pkt_count),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b, input logic last);
      in_valid = 1'b1;
      in_data  = b;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
      read     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_ready",    ready, 0);
      chk("rst_data",     data, 8'h00);
      chk("rst_in_full",  in_full, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_pkt",      pkt_count, 0);

      // 1: store-and-forward gating
      push(8'hAA, 0);
      chk("t1_ready_aa", ready, 0);
      push(8'hBB, 0);
      chk("t1_ready_bb", ready, 0);
      push(8'hCC, 1);
      chk("t1_ready_cc", ready, 0);
      chk("t1_pkt",      pkt_count, 1);
      tick();
      chk("t1_ready_up", ready, 1);
      chk("t1_head",     data, 8'hAA);

      // 2: FWFT readout with read held
      read = 1'b1;
      tick();
      chk("t2_data_bb", data, 8'hBB);
      tick();
      chk("t2_data_cc", data, 8'hCC);
      chk("t2_ready_cc", ready, 1);
      tick();
      chk("t2_ready_dn", ready, 0);
      chk("t2_pkt",      pkt_count, 0);
      chk("t2_data_0",   data, 8'h00);
      read = 1'b0;

      // 3: two packets back-to-back, no bubble
      push(8'h01, 0);
      push(8'h02, 1);
      push(8'h03, 1);
      chk("t3_pkt2",  pkt_count, 2);
      chk("t3_ready", ready, 1);
      chk("t3_d01",   data, 8'h01);
      read = 1'b1;
      tick();
      chk("t3_d02",   data, 8'h02);
      chk("t3_rdy2",  ready, 1);
      tick();
      chk("t3_d03",   data, 8'h03);
      chk("t3_rdy3",  ready, 1);
      chk("t3_pkt1",  pkt_count, 1);
      tick();
      chk("t3_ready_dn", ready, 0);
      chk("t3_pkt0",     pkt_count, 0);
      read = 1'b0;

      // 4: fill to DEPTH, overflow, then verify contents untouched
      for (int i = 0; i < 16; i++) begin
         chk("t4_not_full", in_full, 0);
         push(8'h40 + 8'(i), (i == 15));
      end
      chk("t4_full",  in_full, 1);
      chk("t4_pkt",   pkt_count, 1);
      chk("t4_ovf0",  overflow, 0);
      push(8'hEE, 1);
      chk("t4_ovf1",  overflow, 1);
      chk("t4_full2", in_full, 1);
      chk("t4_pkt2",  pkt_count, 1);
      chk("t4_ready", ready, 1);
      read = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t4_data", data, 8'h40 + 8'(i));
         tick();
         if (i == 0)
            chk("t4_unfull", in_full, 0);
      end
      read = 1'b0;
      chk("t4_ready_dn", ready, 0);
      chk("t4_pkt0",     pkt_count, 0);
      chk("t4_empty",    in_full, 0);

      // 5: write last byte while popping last byte of previous packet
      push(8'h51, 0);
      push(8'h52, 1);
      tick();
      chk("t5_ready", ready, 1);
      chk("t5_d51",   data, 8'h51);
      read = 1'b1;
      tick();
      chk("t5_d52",   data, 8'h52);
      in_valid = 1'b1;
      in_data  = 8'h61;
      in_last  = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("t5_pkt",   pkt_count, 1);
      chk("t5_rdy",   ready, 1);
      chk("t5_d61",   data, 8'h61);
      tick();
      chk("t5_ready_dn", ready, 0);
      chk("t5_pkt0",     pkt_count, 0);
      read = 1'b0;

      // 6: reset mid-read with two packets stored
      push(8'h71, 0);
      push(8'h72, 1);
      push(8'h73, 1);
      chk("t6_pkt2", pkt_count, 2);
      read = 1'b1;
      tick();
      chk("t6_d72",  data, 8'h72);
      chk("t6_ovf_sticky", overflow, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      read  = 1'b0;
      chk("t6_ready",    ready, 0);
      chk("t6_pkt",      pkt_count, 0);
      chk("t6_in_full",  in_full, 0);
      chk("t6_overflow", overflow, 0);
      chk("t6_data",     data, 8'h00);
      push(8'h81, 1);
      tick();
      chk("t6_post_ready", ready, 1);
      chk("t6_post_data",  data, 8'h81);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
